parity_frame_chk: RTL and testbench

Parametrised, streaming successor of the single-word odd/even parity checker. It keeps the registered per-word check (`check`) and adds frame-level behaviour: it XOR-accumulates parity across a multi-word frame delimited by `bus_valid`/`bus_last`, reports a per-frame verdict, and aborts over-long frames. It also keeps a saturating failure counter. It sits on the receive datapath between the deserialiser and the frame consumer.

---
 rtl/parity_pkg.sv | 20 ++
 rtl/parity_word.sv | 30 +++
 rtl/parity_frame_chk.sv | 158 +++++++++++++++
 tb/tb_parity_frame_chk.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/parity_pkg.sv
// Shared definitions for the parity checker family.
//   PAR_EVEN / PAR_ODD : encodings of the sel / mode bit
//   pfc_state_t        : frame FSM states (IDLE, ACCUM)
//   frame_verdict()    : maps (mode, XOR of all bits) to a pass/fail verdict
package parity_pkg;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } pfc_state_t;

    // acc is the XOR of every bit seen, i.e. 1 when the count of ones is odd.
    function automatic logic frame_verdict(input logic mode, input logic acc);
        return (mode == PAR_ODD) ? acc : ~acc;
    endfunction

endpackage

// File: rtl/parity_word.sv
// Registered single-word parity check.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : data word (WIDTH bits)
//   sel        : 1 = odd parity, 0 = even parity
//   check      : registered result, sel ? ^bus : ~^bus
module parity_word
    import parity_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] bus,
    input  logic             sel,
    output logic             check
);

    logic r_check;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_check <= 1'b0;
        end else begin
            r_check <= frame_verdict(sel, ^bus);
        end
    end

    assign check = r_check;

endmodule

// File: rtl/parity_frame_chk.sv
// Streaming frame parity checker.
//   clk, rst_n   : clock, asynchronous active-low reset
//   bus, sel     : data word and parity mode (1 = odd)
//   bus_valid    : word accepted this cycle
//   bus_last     : accepted word ends the frame
//   err_clr      : synchronous clear of err_cnt
//   check        : registered per-word parity result
//   busy         : multi-word frame in progress
//   frame_done   : one-cycle pulse, verdict valid
//   frame_ok     : frame verdict, held until next frame_done
//   frame_ovf    : last verdict was an overflow abort
//   word_cnt     : words accepted in current / last frame
//   err_cnt      : saturating count of failed frames
module parity_frame_chk
    import parity_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int FRAME_MAX = 16,
    parameter int ERR_W     = 8,
    localparam int CW       = $clog2(FRAME_MAX + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] bus,
    input  logic             sel,
    input  logic             bus_valid,
    input  logic             bus_last,
    input  logic             err_clr,
    output logic             check,
    output logic             busy,
    output logic             frame_done,
    output logic             frame_ok,
    output logic             frame_ovf,
    output logic [CW-1:0]    word_cnt,
    output logic [ERR_W-1:0] err_cnt
);

    pfc_state_t       r_state, w_state_next;
    logic             r_acc, w_acc_next;
    logic             r_mode, w_mode_next;
    logic [CW-1:0]    r_cnt, w_cnt_next;
    logic             r_done, w_done_next;
    logic             r_ok, w_ok_next;
    logic             r_ovf, w_ovf_next;
    logic [ERR_W-1:0] r_err, w_err_next;

    logic             w_word_par;
    logic             w_acc_upd;
    logic             w_fail;
    logic [CW-1:0]    w_cnt_inc;

    parity_word #(.WIDTH(WIDTH)) u_word (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .sel   (sel),
        .check (check)
    );

    assign w_word_par = ^bus;
    assign w_acc_upd  = r_acc ^ w_word_par;
    // Saturate at the counter width so an oversized frame can never wrap to 0.
    assign w_cnt_inc  = (r_cnt == {CW{1'b1}}) ? r_cnt : r_cnt + CW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_acc   <= 1'b0;
            r_mode  <= 1'b0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_ok    <= 1'b0;
            r_ovf   <= 1'b0;
            r_err   <= '0;
        end else begin
            r_state <= w_state_next;
            r_acc   <= w_acc_next;
            r_mode  <= w_mode_next;
            r_cnt   <= w_cnt_next;
            r_done  <= w_done_next;
            r_ok    <= w_ok_next;
            r_ovf   <= w_ovf_next;
            r_err   <= w_err_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_acc_next   = r_acc;
        w_mode_next  = r_mode;
        w_cnt_next   = r_cnt;
        w_done_next  = 1'b0;
        w_ok_next    = r_ok;
        w_ovf_next   = r_ovf;

        unique case (r_state)
            IDLE: begin
                if (bus_valid) begin
                    w_mode_next = sel;
                    w_acc_next  = w_word_par;
                    w_cnt_next  = CW'(1);
                    if (bus_last) begin
                        w_done_next = 1'b1;
                        w_ok_next   = frame_verdict(sel, w_word_par);
                        w_ovf_next  = 1'b0;
                    end else begin
                        w_state_next = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (bus_valid) begin
                    if (bus_last) begin
                        // A last flag wins even on the word that would overflow.
                        w_acc_next   = w_acc_upd;
                        w_cnt_next   = w_cnt_inc;
                        w_done_next  = 1'b1;
                        w_ok_next    = frame_verdict(r_mode, w_acc_upd);
                        w_ovf_next   = 1'b0;
                        w_state_next = IDLE;
                    end else if (r_cnt == CW'(FRAME_MAX)) begin
                        // Abort: word_cnt stays at FRAME_MAX, the overflowing
                        // word is dropped and later words start a new frame.
                        w_done_next  = 1'b1;
                        w_ok_next    = 1'b0;
                        w_ovf_next   = 1'b1;
                        w_state_next = IDLE;
                    end else begin
                        w_acc_next = w_acc_upd;
                        w_cnt_next = w_cnt_inc;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Failure is decided from the next-state verdict so err_cnt moves on the
    // same edge that raises frame_done.
    assign w_fail = w_done_next & ~w_ok_next;

    always_comb begin
        w_err_next = r_err;
        if (err_clr) begin
            w_err_next = w_fail ? ERR_W'(1) : '0;
        end else if (w_fail && (r_err != {ERR_W{1'b1}})) begin
            w_err_next = r_err + ERR_W'(1);
        end
    end

    assign busy       = (r_state == ACCUM);
    assign frame_done = r_done;
    assign frame_ok   = r_ok;
    assign frame_ovf  = r_ovf;
    assign word_cnt   = r_cnt;
    assign err_cnt    = r_err;

endmodule

// File: tb/tb_parity_frame_chk.sv
// Directed testbench for parity_frame_chk (WIDTH=32, FRAME_MAX=4, ERR_W=2).
module tb_parity_frame_chk;

    localparam int WIDTH     = 32;
    localparam int FRAME_MAX = 4;
    localparam int ERR_W     = 2;
    localparam int CW        = $clog2(FRAME_MAX + 1);

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] bus;
    logic             sel;
    logic             bus_valid;
    logic             bus_last;
    logic             err_clr;
    logic             check;
    logic             busy;
    logic             frame_done;
    logic             frame_ok;
    logic             frame_ovf;
    logic [CW-1:0]    word_cnt;
    logic [ERR_W-1:0] err_cnt;

    int checks = 0;
    int errors = 0;

    parity_frame_chk #(
        .WIDTH     (WIDTH),
        .FRAME_MAX (FRAME_MAX),
        .ERR_W     (ERR_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .sel        (sel),
        .bus_valid  (bus_valid),
        .bus_last   (bus_last),
        .err_clr    (err_clr),
        .check      (check),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_ok   (frame_ok),
        .frame_ovf  (frame_ovf),
        .word_cnt   (word_cnt),
        .err_cnt    (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] b, input logic s, input logic v, input logic l);
        bus       = b;
        sel       = s;
        bus_valid = v;
        bus_last  = l;
    endtask

    task automatic chk_frame(input string tag, input logic ok, input logic ovf,
                             input logic [31:0] cnt, input logic [31:0] err);
        chk({tag, ".done"}, 32'(frame_done), 32'd1);
        chk({tag, ".ok"},   32'(frame_ok),   32'(ok));
        chk({tag, ".ovf"},  32'(frame_ovf),  32'(ovf));
        chk({tag, ".cnt"},  32'(word_cnt),   cnt);
        chk({tag, ".err"},  32'(err_cnt),    err);
        chk({tag, ".busy"}, 32'(busy),       32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n   = 1'b0;
        err_clr = 1'b0;
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        #3;
        chk("rst.check", 32'(check),      32'd0);
        chk("rst.busy",  32'(busy),       32'd0);
        chk("rst.done",  32'(frame_done), 32'd0);
        chk("rst.ok",    32'(frame_ok),   32'd0);
        chk("rst.ovf",   32'(frame_ovf),  32'd0);
        chk("rst.cnt",   32'(word_cnt),   32'd0);
        chk("rst.err",   32'(err_cnt),    32'd0);
        tick;
        rst_n = 1'b1;

        // Legacy per-word check, bus_valid low
        drive(32'h0, 1'b0, 1'b0, 1'b0); tick; chk("word.0_even", 32'(check), 32'd1);
        drive(32'h1, 1'b0, 1'b0, 1'b0); tick; chk("word.1_even", 32'(check), 32'd0);
        drive(32'h1, 1'b1, 1'b0, 1'b0); tick; chk("word.1_odd",  32'(check), 32'd1);
        chk("word.no_done", 32'(frame_done), 32'd0);

        // Odd frame 1,3,7: six ones -> fail
        drive(32'h1, 1'b1, 1'b1, 1'b0); tick;
        chk("odd.busy1", 32'(busy), 32'd1);
        chk("odd.cnt1",  32'(word_cnt), 32'd1);
        drive(32'h3, 1'b1, 1'b1, 1'b0); tick;
        drive(32'h7, 1'b1, 1'b1, 1'b1); tick;
        chk_frame("odd", 1'b0, 1'b0, 32'd3, 32'd1);
        drive(32'h0, 1'b0, 1'b0, 1'b0); tick;
        chk("odd.pulse_end", 32'(frame_done), 32'd0);
        chk("odd.ok_held",   32'(frame_ok),   32'd0);

        // Same words, even mode -> pass
        drive(32'h1, 1'b0, 1'b1, 1'b0); tick;
        drive(32'h3, 1'b0, 1'b1, 1'b0); tick;
        drive(32'h7, 1'b0, 1'b1, 1'b1); tick;
        chk_frame("even", 1'b1, 1'b0, 32'd3, 32'd1);

        // Mode latching: sel toggles after the first word; two ones -> odd fails
        drive(32'h1, 1'b1, 1'b1, 1'b0); tick;
        drive(32'h1, 1'b0, 1'b1, 1'b0); tick;
        drive(32'h0, 1'b1, 1'b1, 1'b0); tick;
        drive(32'h0, 1'b0, 1'b1, 1'b1); tick;
        chk_frame("latch", 1'b0, 1'b0, 32'd4, 32'd2);

        // Overflow: five words, no last
        for (int i = 0; i < 4; i++) begin
            drive(32'h1, 1'b0, 1'b1, 1'b0); tick;
        end
        chk("ovf.busy4", 32'(busy), 32'd1);
        chk("ovf.cnt4",  32'(word_cnt), 32'd4);
        chk("ovf.nodone4", 32'(frame_done), 32'd0);
        drive(32'h1, 1'b0, 1'b1, 1'b0); tick;
        chk_frame("ovf", 1'b0, 1'b1, 32'd4, 32'd3);
        // Next word immediately starts a fresh single-word frame (two ones, even)
        drive(32'h3, 1'b0, 1'b1, 1'b1); tick;
        chk_frame("ovf_next", 1'b1, 1'b0, 32'd1, 32'd3);

        // Saturation: another failure keeps err_cnt at 3
        drive(32'h0, 1'b1, 1'b1, 1'b1); tick;
        chk_frame("sat", 1'b0, 1'b0, 32'd1, 32'd3);
        // Clear together with a failure -> 1
        err_clr = 1'b1;
        drive(32'h0, 1'b1, 1'b1, 1'b1); tick;
        chk_frame("clr_fail", 1'b0, 1'b0, 32'd1, 32'd1);
        // Clear alone -> 0
        drive(32'h0, 1'b0, 1'b0, 1'b0); tick;
        err_clr = 1'b0;
        chk("clr_only.err",  32'(err_cnt),    32'd0);
        chk("clr_only.done", 32'(frame_done), 32'd0);

        // Back-to-back single-word frames
        drive(32'h1, 1'b1, 1'b1, 1'b1); tick; chk_frame("b2b0", 1'b1, 1'b0, 32'd1, 32'd0);
        drive(32'h0, 1'b1, 1'b1, 1'b1); tick; chk_frame("b2b1", 1'b0, 1'b0, 32'd1, 32'd1);
        drive(32'h3, 1'b0, 1'b1, 1'b1); tick; chk_frame("b2b2", 1'b1, 1'b0, 32'd1, 32'd1);
        drive(32'hF, 1'b1, 1'b1, 1'b1); tick; chk_frame("b2b3", 1'b0, 1'b0, 32'd1, 32'd2);

        // Reset after 3 of 5 words
        for (int i = 0; i < 3; i++) begin
            drive(32'h1, 1'b0, 1'b1, 1'b0); tick;
        end
        chk("mid.busy", 32'(busy), 32'd1);
        chk("mid.cnt",  32'(word_cnt), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.check", 32'(check),      32'd0);
        chk("arst.busy",  32'(busy),       32'd0);
        chk("arst.done",  32'(frame_done), 32'd0);
        chk("arst.ok",    32'(frame_ok),   32'd0);
        chk("arst.ovf",   32'(frame_ovf),  32'd0);
        chk("arst.cnt",   32'(word_cnt),   32'd0);
        chk("arst.err",   32'(err_cnt),    32'd0);
        tick;
        chk("arst.no_done", 32'(frame_done), 32'd0);
        rst_n = 1'b1;
        // Fresh frame 0x1, 0x0 even: one one -> fail, two words
        drive(32'h1, 1'b0, 1'b1, 1'b0); tick;
        chk("post.no_done", 32'(frame_done), 32'd0);
        drive(32'h0, 1'b0, 1'b1, 1'b1); tick;
        chk_frame("post", 1'b0, 1'b0, 32'd2, 32'd1);
        drive(32'h0, 1'b0, 1'b0, 1'b0); tick;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
